// File: rtl/anu_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : anu_mem_pkg
// Description : Shared constants for the core's data-memory interface:
//               store-width encoding and responder FSM state codes.
// Revision    : 1.0 - initial release
// ============================================================================
package anu_mem_pkg;

    // Store-width codes, identical to the core's mem_access_mode encoding
    localparam logic [1:0] MODE_NONE = 2'b00;
    localparam logic [1:0] MODE_BYTE = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;
    localparam logic [1:0] MODE_WORD = 2'b11;

    // Responder FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_be_gen.sv
`default_nettype none
// ============================================================================
// Module      : dmem_be_gen
// Description : Combinational store lane steering. Turns {mode, byte offset}
//               into a 4-bit byte enable and a misalignment flag, and shifts
//               the right-aligned store data up into its target lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_be_gen
    import anu_mem_pkg::*;
(
    input  logic [1:0]  i_mode,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_be,
    output logic        o_misalign,
    output logic [31:0] o_wdata_sh
);

    // Byte enables and alignment check per store width; loads (MODE_NONE)
    // enable no lanes and are never misaligned
    always_comb begin
        o_be       = 4'b0000;
        o_misalign = 1'b0;
        case (i_mode)
            MODE_BYTE: o_be = 4'b0001 << i_off;
            MODE_HALF: begin
                o_be       = 4'b0011 << i_off;
                o_misalign = i_off[0];
            end
            MODE_WORD: begin
                o_be       = 4'b1111;
                o_misalign = (i_off != 2'b00);
            end
            default: ;
        endcase
    end

    // Lane k receives wdata byte (k - off)
    assign o_wdata_sh = i_wdata << {i_off, 3'b000};

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Data-memory responder for the core's load/store port. Holds
//               the core in stall for WAIT_CYCLES+1 cycles per access, then
//               performs the store or returns the right-aligned load word.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import anu_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  mem_access_mode,
    input  logic        ld_req,
    output logic [31:0] rdata,
    output logic        stall,
    output logic        misalign_err,
    output logic        addr_err
);

    localparam int         c_IDX_W   = $clog2(DEPTH_WORDS);
    localparam bit         c_NO_WAIT = (WAIT_CYCLES == 0);
    // The IDLE cycle that sees the request counts as the first stall cycle,
    // so BUSY lasts WAIT_CYCLES cycles and the counter starts one lower.
    localparam logic [3:0] c_CNT_INIT = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_stall;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_mode;
    logic        r_is_load;
    logic [3:0]  r_cnt;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_in_idle;
    logic               w_execute;
    logic [31:0]        w_ex_addr;
    logic [31:0]        w_ex_wdata;
    logic [1:0]         w_ex_mode;
    logic               w_ex_load;
    logic [c_IDX_W-1:0] w_idx;
    logic [1:0]         w_off;
    logic               w_addr_bad;
    logic [3:0]         w_be;
    logic               w_misalign;
    logic [31:0]        w_wdata_sh;
    logic               w_we;
    logic [31:0]        w_rd_shift;

    assign w_req     = (mem_access_mode != MODE_NONE) | ld_req;
    assign w_in_idle = (r_state == ST_IDLE);

    // With zero wait states the access executes straight out of IDLE, so the
    // live inputs are used; otherwise the values captured on entry to BUSY.
    assign w_ex_addr  = w_in_idle ? mem_addr        : r_addr;
    assign w_ex_wdata = w_in_idle ? wdata           : r_wdata;
    assign w_ex_mode  = w_in_idle ? mem_access_mode : r_mode;
    assign w_ex_load  = w_in_idle ? (ld_req & (mem_access_mode == MODE_NONE)) : r_is_load;

    assign w_execute = (w_in_idle & w_req & c_NO_WAIT) |
                       ((r_state == ST_BUSY) & (r_cnt == 4'd0));

    assign w_idx      = w_ex_addr[c_IDX_W+1:2];
    assign w_off      = w_ex_addr[1:0];
    assign w_addr_bad = ((w_ex_addr >> (c_IDX_W + 2)) != 32'd0);

    dmem_be_gen u_be_gen (
        .i_mode     (w_ex_mode),
        .i_off      (w_off),
        .i_wdata    (w_ex_wdata),
        .o_be       (w_be),
        .o_misalign (w_misalign),
        .o_wdata_sh (w_wdata_sh)
    );

    // Loads never enable lanes, so only valid stores write
    assign w_we       = w_execute & ~w_misalign & ~w_addr_bad;
    assign w_rd_shift = r_mem[w_idx] >> {w_off, 3'b000};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and stall decode
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_stall = w_req;
                if (w_req) begin
                    w_next_state = c_NO_WAIT ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Stall drops the moment reset asserts, even with a request still driven
    assign stall = w_stall & ~rst;

    // Request capture, wait counter, load data and error pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_mode       <= MODE_NONE;
            r_is_load    <= 1'b0;
            r_cnt        <= '0;
            rdata        <= '0;
            misalign_err <= 1'b0;
            addr_err     <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            addr_err     <= 1'b0;
            if (w_in_idle && w_req) begin
                r_addr    <= mem_addr;
                r_wdata   <= wdata;
                r_mode    <= mem_access_mode;
                r_is_load <= ld_req & (mem_access_mode == MODE_NONE);
                r_cnt     <= c_CNT_INIT;
            end
            if (r_state == ST_BUSY && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_execute) begin
                misalign_err <= w_misalign;
                addr_err     <= w_addr_bad;
                if (w_ex_load) begin
                    rdata <= (w_misalign | w_addr_bad) ? 32'd0 : w_rd_shift;
                end
            end
        end
    end

    // Storage array, byte-lane writes, deliberately not reset
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (w_we && w_be[k]) begin
                r_mem[w_idx][8*k +: 8] <= w_wdata_sh[8*k +: 8];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder. Instance A
//               runs with two wait states, instance B with none.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
    logic [1:0]  a_mode = '0;
    logic        a_ld = 1'b0, a_stall, a_merr, a_aerr;

    logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
    logic [1:0]  b_mode = '0;
    logic        b_ld = 1'b0, b_stall, b_merr, b_aerr;

    int total = 0;
    int bad   = 0;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) u_dut_a (
        .clk             (clk),
        .rst             (rst),
        .mem_addr        (a_addr),
        .wdata           (a_wdata),
        .mem_access_mode (a_mode),
        .ld_req          (a_ld),
        .rdata           (a_rdata),
        .stall           (a_stall),
        .misalign_err    (a_merr),
        .addr_err        (a_aerr)
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) u_dut_b (
        .clk             (clk),
        .rst             (rst),
        .mem_addr        (b_addr),
        .wdata           (b_wdata),
        .mem_access_mode (b_mode),
        .ld_req          (b_ld),
        .rdata           (b_rdata),
        .stall           (b_stall),
        .misalign_err    (b_merr),
        .addr_err        (b_aerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full access on instance A (sel=0) or B (sel=1): drive at a falling
    // edge, count sampled stall cycles, capture DONE outputs, then check the
    // following cycle is idle with the error pulses gone.
    task automatic access(input bit sel, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] mode, input logic ld,
                          output int n, output logic [31:0] rd,
                          output logic me, output logic ae);
        n = 0;
        @(negedge clk);
        if (sel) begin b_addr = addr; b_wdata = wd; b_mode = mode; b_ld = ld; end
        else     begin a_addr = addr; a_wdata = wd; a_mode = mode; a_ld = ld; end
        #1;
        while ((sel ? b_stall : a_stall) && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        rd = sel ? b_rdata : a_rdata;
        me = sel ? b_merr  : a_merr;
        ae = sel ? b_aerr  : a_aerr;
        a_addr = '0; a_wdata = '0; a_mode = 2'b00; a_ld = 1'b0;
        b_addr = '0; b_wdata = '0; b_mode = 2'b00; b_ld = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_after_done_stall", {31'd0, sel ? b_stall : a_stall}, 32'd0);
        chk("pulse_cleared", {30'd0, sel ? b_merr : a_merr, sel ? b_aerr : a_aerr}, 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] rd;
        logic        me, ae;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_stall", {31'd0, a_stall}, 32'd0);
        chk("reset_rdata", a_rdata, 32'd0);
        chk("reset_errs", {30'd0, a_merr, a_aerr}, 32'd0);
        rst = 1'b0;

        // Word store then load
        access(0, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, n, rd, me, ae);
        chk("st_word_stall_cycles", n, 3);
        chk("st_word_errs", {30'd0, me, ae}, 32'd0);
        access(0, 32'h10, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("ld_word_stall_cycles", n, 3);
        chk("ld_word_rdata", rd, 32'hDEADBEEF);

        // Byte store into existing word
        access(0, 32'h20, 32'h11223344, 2'b11, 1'b0, n, rd, me, ae);
        access(0, 32'h22, 32'h000000AA, 2'b01, 1'b0, n, rd, me, ae);
        access(0, 32'h20, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("byte_merge_word", rd, 32'h11AA3344);
        access(0, 32'h22, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("byte_load_off2", rd, 32'h000011AA);

        // Half store at offset 2
        access(0, 32'h24, 32'h55667788, 2'b11, 1'b0, n, rd, me, ae);
        access(0, 32'h26, 32'h0000BEEF, 2'b10, 1'b0, n, rd, me, ae);
        access(0, 32'h24, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("half_merge_word", rd, 32'hBEEF7788);
        access(0, 32'h26, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("half_load_off2", rd, 32'h0000BEEF);

        // Misaligned word store is dropped
        access(0, 32'h30, 32'hCAFEF00D, 2'b11, 1'b0, n, rd, me, ae);
        access(0, 32'h31, 32'h12345678, 2'b11, 1'b0, n, rd, me, ae);
        chk("misalign_flags", {30'd0, me, ae}, 32'h2);
        access(0, 32'h30, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("misalign_word_unchanged", rd, 32'hCAFEF00D);

        // Out-of-range load returns zero
        access(0, 32'h400, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("range_flags", {30'd0, me, ae}, 32'h1);
        chk("range_load_rdata", rd, 32'h0);

        // Both errors together; rdata holds across a store
        access(0, 32'h10, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        access(0, 32'h403, 32'h0000FFFF, 2'b10, 1'b0, n, rd, me, ae);
        chk("both_err_flags", {30'd0, me, ae}, 32'h3);
        chk("rdata_held_over_store", rd, 32'hDEADBEEF);

        // Store wins over a simultaneous load request
        access(0, 32'h12, 32'h00000077, 2'b01, 1'b1, n, rd, me, ae);
        chk("store_priority_rdata", rd, 32'hDEADBEEF);
        access(0, 32'h10, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("store_priority_word", rd, 32'hDE77BEEF);
        access(0, 32'h13, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("byte_load_off3", rd, 32'h000000DE);

        // Zero-wait instance: one stall cycle per access
        access(1, 32'h8, 32'hA5A5A5A5, 2'b11, 1'b0, n, rd, me, ae);
        chk("w0_store_stall_cycles", n, 1);
        access(1, 32'h8, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("w0_load_stall_cycles", n, 1);
        chk("w0_load_rdata", rd, 32'hA5A5A5A5);

        // Reset during the second BUSY cycle of a store
        access(0, 32'h40, 32'h01020304, 2'b11, 1'b0, n, rd, me, ae);
        @(negedge clk);
        a_addr = 32'h40; a_wdata = 32'hFFFFFFFF; a_mode = 2'b11; a_ld = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midreset_stall_drop", {31'd0, a_stall}, 32'd0);
        chk("midreset_rdata_clear", a_rdata, 32'd0);
        @(negedge clk);
        a_addr = '0; a_wdata = '0; a_mode = 2'b00;
        rst = 1'b0;
        access(0, 32'h40, 32'h0, 2'b00, 1'b1, n, rd, me, ae);
        chk("midreset_word_unchanged", rd, 32'h01020304);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
